// File: rtl/voice_mix_requester_if.sv
// Voice mix handshake bundle: codec request in, per-voice generate/ready/sample
// exchange, and the mixed codec sample with its status flags.
interface voice_mix_requester_if #(
  parameter int NUM_VOICES = 3,
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 16
);
  logic                           codec_sample_request;
  logic                           play_enable;
  logic [NUM_VOICES-1:0]          voice_active;
  logic [NUM_VOICES-1:0]          gen_next_out;
  logic [NUM_VOICES-1:0]          voice_sample_ready;
  logic [NUM_VOICES*IN_WIDTH-1:0] voice_sample;
  logic [OUT_WIDTH-1:0]           mixed_sample;
  logic                           mixed_valid;
  logic                           clip_flag;
  logic                           timeout_flag;
  logic                           overrun_flag;

  // The mixer drives the handshake: it requests samples and presents the mix.
  modport master (
    input  codec_sample_request, play_enable, voice_active,
           voice_sample_ready, voice_sample,
    output gen_next_out, mixed_sample, mixed_valid,
           clip_flag, timeout_flag, overrun_flag
  );

  // Codec, voices and play control seen from the other side.
  modport slave (
    output codec_sample_request, play_enable, voice_active,
           voice_sample_ready, voice_sample,
    input  gen_next_out, mixed_sample, mixed_valid,
           clip_flag, timeout_flag, overrun_flag
  );
endinterface

// File: rtl/voice_mix_requester.sv
// Voice mix requester: on a codec request, asks every active voice for its next
// sample, collects the replies (with a timeout), sums them, saturates to the
// codec width and presents one registered sample with a one-cycle valid pulse.
module voice_mix_requester #(
  parameter int NUM_VOICES = 3,
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  voice_mix_requester_if.master bus
);

  // Two guard bits hold the sum of up to four full-scale voices.
  localparam int ACC_W = IN_WIDTH + 2;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT, SUM, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [NUM_VOICES-1:0]      act_mask;
  logic [NUM_VOICES-1:0]      captured;
  logic [NUM_VOICES-1:0]      capture_now;
  logic signed [IN_WIDTH-1:0] cap [NUM_VOICES];
  logic [7:0]                 wait_cnt;
  logic                       timed_out;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum_c;
  logic [OUT_WIDTH-1:0]       clamped_c;
  logic                       clip_c;
  logic                       req_accept;
  logic                       overrun_hit;
  logic                       all_done;
  logic                       wait_expired;

  logic [NUM_VOICES-1:0]      gen_next_q;
  logic [OUT_WIDTH-1:0]       mixed_sample_q;
  logic                       mixed_valid_q;
  logic                       clip_q;
  logic                       timeout_q;
  logic                       overrun_q;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request decode, capture qualification and next-state selection.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    req_accept   = 1'b0;
    overrun_hit  = 1'b0;
    capture_now  = '0;
    all_done     = 1'b0;
    wait_expired = 1'b0;
    state_nxt    = state;

    // The cycle carrying mixed_valid still belongs to the finished transaction.
    req_accept  = bus.codec_sample_request && (state == IDLE) && !mixed_valid_q;
    overrun_hit = bus.codec_sample_request && !req_accept;

    if (state == WAIT) capture_now = act_mask & bus.voice_sample_ready & ~captured;
    all_done     = ((captured | capture_now) == act_mask);
    wait_expired = (wait_cnt == TIMEOUT_LAST);

    case (state)
      IDLE: begin
        if (req_accept)
          state_nxt = (bus.play_enable && (|bus.voice_active)) ? REQUEST : SUM;
      end
      REQUEST: state_nxt = WAIT;
      WAIT: begin
        if (all_done || wait_expired) state_nxt = SUM;
      end
      SUM:     state_nxt = OUTPUT;
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum of captured samples and saturation of the registered accumulator.
  always_comb begin
    sum_c     = '0;
    clip_c    = 1'b0;
    clamped_c = acc[OUT_WIDTH-1:0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (captured[i]) sum_c = sum_c + ACC_W'(cap[i]);
    end
    if (acc > OUT_MAX) begin
      clamped_c = OUT_MAX[OUT_WIDTH-1:0];
      clip_c    = 1'b1;
    end else if (acc < OUT_MIN) begin
      clamped_c = OUT_MIN[OUT_WIDTH-1:0];
      clip_c    = 1'b1;
    end
  end

  // Transaction datapath: active mask, captures, wait counter and accumulator.
  // NOTE: the capture array is reset along with everything else so an
  // abandoned transaction can never leak old samples into a later sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_mask  <= '0;
      captured  <= '0;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      acc       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) cap[i] <= '0;
    end else begin
      if (req_accept) begin
        act_mask  <= bus.play_enable ? bus.voice_active : '0;
        captured  <= '0;
        timed_out <= 1'b0;
      end
      if (state == REQUEST) wait_cnt <= '0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        captured <= captured | capture_now;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (capture_now[i]) cap[i] <= bus.voice_sample[i*IN_WIDTH +: IN_WIDTH];
        end
        if (!all_done && wait_expired) timed_out <= 1'b1;
      end
      if (state == SUM) acc <= sum_c;
    end
  end

  // Registered outputs: generate pulse, mixed sample with flags, sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_next_q     <= '0;
      mixed_sample_q <= '0;
      mixed_valid_q  <= 1'b0;
      clip_q         <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      gen_next_q    <= (state_nxt == REQUEST) ? bus.voice_active : '0;
      mixed_valid_q <= (state == OUTPUT);
      if (state == OUTPUT) begin
        mixed_sample_q <= clamped_c;
        clip_q         <= clip_c;
        timeout_q      <= timed_out;
      end
      if (overrun_hit) overrun_q <= 1'b1;
    end
  end

  assign bus.gen_next_out = gen_next_q;
  assign bus.mixed_sample = mixed_sample_q;
  assign bus.mixed_valid  = mixed_valid_q;
  assign bus.clip_flag    = clip_q;
  assign bus.timeout_flag = timeout_q;
  assign bus.overrun_flag = overrun_q;

endmodule

// File: tb/tb_voice_mix_requester.sv
// Bench for voice_mix_requester: directed scenarios plus randomized
// transactions, each predicted by a reference model from per-voice reply
// delays; a monitor pops the expected result whenever mixed_valid is seen.
module tb_voice_mix_requester;
  localparam int NV    = 3;
  localparam int IW    = 18;
  localparam int OW    = 16;
  localparam int TO    = 15;
  localparam int NEVER = 1000;
  localparam int MAXV  = (2 ** (OW - 1)) - 1;
  localparam int MINV  = -(2 ** (OW - 1));

  typedef struct packed {
    logic [OW-1:0] sample;
    logic          clip;
    logic          to;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  voice_mix_requester_if #(.NUM_VOICES(NV), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  voice_mix_requester #(
    .NUM_VOICES(NV), .IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic          exp_overrun = 1'b0;
  logic [OW-1:0] last_sample = '0;
  logic          last_clip   = 1'b0;
  logic          last_to     = 1'b0;
  int            txn_s[NV];
  int            txn_d[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a voice counts when it is active and replies within the
  // TIMEOUT wait cycles; the sum is clamped to the codec range.
  function automatic void model(input logic play, input logic [NV-1:0] active,
                                output exp_t e, output int lat);
    int  sum  = 0;
    int  maxd = 0;
    logic miss = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (play && active[i]) begin
        if (txn_d[i] < TO) begin
          sum += txn_s[i];
          if (txn_d[i] > maxd) maxd = txn_d[i];
        end else begin
          miss = 1'b1;
        end
      end
    end
    e.clip = 1'b0;
    if (sum > MAXV) begin
      sum = MAXV; e.clip = 1'b1;
    end else if (sum < MINV) begin
      sum = MINV; e.clip = 1'b1;
    end
    e.sample = OW'(sum);
    e.to     = miss;
    if (!play || active == '0) lat = 2;
    else if (miss)             lat = 3 + TO;
    else                       lat = 4 + maxd;
  endfunction

  task automatic set_txn(input int s0, input int s1, input int s2,
                         input int d0, input int d1, input int d2);
    txn_s[0] = s0; txn_s[1] = s1; txn_s[2] = s2;
    txn_d[0] = d0; txn_d[1] = d1; txn_d[2] = d2;
  endtask

  // Voice behaviour for reply cycle k: the true sample with ready on cycle d,
  // then (level mode) ready held with junk data that must not be recaptured.
  task automatic drive_voices(input int k, input logic [NV-1:0] active, input logic pulse);
    for (int i = 0; i < NV; i++) begin
      if (!active[i]) begin
        bus.voice_sample_ready[i]    = 1'($urandom);
        bus.voice_sample[i*IW +: IW] = IW'($urandom);
      end else begin
        bus.voice_sample_ready[i]    = (k == txn_d[i]) || (!pulse && k > txn_d[i]);
        bus.voice_sample[i*IW +: IW] = (k == txn_d[i]) ? IW'(txn_s[i]) : IW'($urandom);
      end
    end
  endtask

  task automatic run_txn(input logic play, input logic [NV-1:0] active,
                         input logic pulse, input logic poke);
    exp_t e;
    int   lat;
    int   edges = 0;
    logic seen  = 1'b0;
    model(play, active, e, lat);
    exp_q.push_back(e);
    @(negedge clk);
    bus.codec_sample_request = 1'b1;
    bus.play_enable          = play;
    bus.voice_active         = active;
    bus.voice_sample_ready   = '0;
    @(posedge clk); #1;
    bus.codec_sample_request = 1'b0;
    bus.play_enable          = 1'($urandom);
    bus.voice_active         = NV'($urandom);
    bus.voice_sample_ready   = NV'($urandom);
    bus.voice_sample         = (NV*IW)'({$urandom, $urandom});
    check("gen_next_pulse", bus.gen_next_out, play ? active : '0);
    while (!seen && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      bus.codec_sample_request = 1'b0;
      if (edges == 1) check("gen_next_cleared", bus.gen_next_out, '0);
      if (poke && edges == 4) check("overrun_set", bus.overrun_flag, 1'b1);
      if (bus.mixed_valid) begin
        seen = 1'b1;
        check("latency", edges, lat);
      end else begin
        drive_voices(edges - 1, active, pulse);
        if (poke && edges == 3) begin
          bus.codec_sample_request = 1'b1;
          exp_overrun = 1'b1;
        end
      end
    end
    if (!seen) check("valid_within_budget", 1'b0, 1'b1);
    bus.voice_sample_ready = '0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compare on each valid, and check outputs hold otherwise.
  always @(negedge clk) begin
    if (reset) begin
      last_sample = '0;
      last_clip   = 1'b0;
      last_to     = 1'b0;
    end else if (bus.mixed_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("mixed_sample", bus.mixed_sample, mon_e.sample);
        check("clip_flag", bus.clip_flag, mon_e.clip);
        check("timeout_flag", bus.timeout_flag, mon_e.to);
        check("overrun_flag", bus.overrun_flag, exp_overrun);
        last_sample = mon_e.sample;
        last_clip   = mon_e.clip;
        last_to     = mon_e.to;
      end
    end else begin
      check("hold_sample", bus.mixed_sample, last_sample);
      check("hold_clip", bus.clip_flag, last_clip);
      check("hold_timeout", bus.timeout_flag, last_to);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.codec_sample_request = 1'b0;
    bus.play_enable          = 1'b0;
    bus.voice_active         = '0;
    bus.voice_sample_ready   = '0;
    bus.voice_sample         = '0;
    #2;
    check("rst_gen_next", bus.gen_next_out, '0);
    check("rst_sample", bus.mixed_sample, '0);
    check("rst_valid", bus.mixed_valid, 1'b0);
    check("rst_clip", bus.clip_flag, 1'b0);
    check("rst_timeout", bus.timeout_flag, 1'b0);
    check("rst_overrun", bus.overrun_flag, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Normal mix, saturation both ways, staggered replies with a missing voice.
    set_txn(1000, -300, 200, 0, 0, 0);          run_txn(1'b1, 3'b111, 1'b0, 1'b0);
    set_txn(30000, 20000, 10000, 0, 0, 0);      run_txn(1'b1, 3'b111, 1'b1, 1'b0);
    set_txn(-40000, -1000, 0, 0, 0, 0);         run_txn(1'b1, 3'b111, 1'b0, 1'b0);
    set_txn(5000, -7000, 9999, 0, 5, NEVER);    run_txn(1'b1, 3'b111, 1'b1, 1'b0);
    set_txn(777, 1234, -555, 0, 0, 0);          run_txn(1'b1, 3'b010, 1'b0, 1'b0);
    set_txn(4000, 4000, 4000, 0, 0, 0);         run_txn(1'b0, 3'b111, 1'b0, 1'b0);
    set_txn(100, 200, 300, 0, 0, 0);            run_txn(1'b1, 3'b000, 1'b0, 1'b0);
    set_txn(14, -2, 8, 14, 3, 14);              run_txn(1'b1, 3'b111, 1'b0, 1'b0);

    // Overrun during WAIT, then a clean transaction showing the flag is sticky.
    set_txn(111, 222, 333, 2, 9, NEVER);        run_txn(1'b1, 3'b111, 1'b0, 1'b1);
    set_txn(1000, -300, 200, 0, 0, 0);          run_txn(1'b1, 3'b111, 1'b0, 1'b0);

    // Reset while waiting: outputs clear at once and no valid follows.
    @(negedge clk);
    bus.codec_sample_request = 1'b1;
    bus.play_enable          = 1'b1;
    bus.voice_active         = 3'b111;
    bus.voice_sample_ready   = '0;
    @(posedge clk); #1;
    bus.codec_sample_request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_gen_next", bus.gen_next_out, '0);
    check("midrst_sample", bus.mixed_sample, '0);
    check("midrst_valid", bus.mixed_valid, 1'b0);
    check("midrst_clip", bus.clip_flag, 1'b0);
    check("midrst_timeout", bus.timeout_flag, 1'b0);
    check("midrst_overrun", bus.overrun_flag, 1'b0);
    exp_overrun = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.voice_sample_ready = '1;
    bus.voice_sample       = (NV*IW)'({$urandom, $urandom});
    repeat (8) @(posedge clk);
    #1;
    bus.voice_sample_ready = '0;
    set_txn(-1500, 2500, 64, 1, 0, 2);          run_txn(1'b1, 3'b111, 1'b1, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic wide = 1'($urandom);
      for (int i = 0; i < NV; i++) begin
        int r = int'($urandom_range(0, 24));
        txn_s[i] = wide ? int'($urandom_range(0, 262143)) - 131072
                        : int'($urandom_range(0, 20000)) - 10000;
        txn_d[i] = (r > 19) ? NEVER : r;
      end
      run_txn(($urandom_range(0, 9) != 0), NV'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
